// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the MIPS core.
// Serves one load or store at a time over valid/ready request and response
// channels, with WAIT_CYCLES wait states between acceptance and the access.
// Misaligned or out-of-range accesses complete with rsp_error and never write.
//
//   state  | meaning
//   IDLE   | ready for a request (req_ready = 1)
//   WAIT   | request captured, counting down wait states; access at count 0
//   RESP   | response presented (rsp_valid = 1) until rsp_ready
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          addr_err;
  logic          accept;
  logic          access;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);

  assign accept   = req_valid && (state == S_IDLE);
  assign access   = (state == S_WAIT) && (cnt == 4'd0);
  assign idx      = addr_q[AW+1:2];
  // Anything above the top word, or not word aligned, is rejected.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:AW+2] != '0);

  // Request capture; contents only matter from acceptance to the access edge.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage write; a reset on the access edge suppresses the store.
  always_ff @(posedge clk) begin
    if (!rst && access && write_q && !addr_err) begin
      mem[idx] <= wdata_q;
    end
  end

  // Sequencer: accept, count down wait states, access, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= WAIT_INIT;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_error <= addr_err;
            rsp_rdata <= (write_q || addr_err) ? 32'd0 : mem[idx];
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
